// File: rtl/subtrator_pkg.sv
// Shared types for the bit-serial subtractor: FSM states and default width.
package subtrator_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam int DEF_WIDTH = 8;
endpackage

// File: rtl/subtrator_serial_if.sv
// Start/done handshake and operand/result bus of the serial subtractor.
interface subtrator_serial_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             borrow_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             a_lt_b;
  logic             eq;

  modport master (
    output start, a, b, borrow_in,
    input  busy, done, diff, borrow_out, a_lt_b, eq
  );

  modport slave (
    input  start, a, b, borrow_in,
    output busy, done, diff, borrow_out, a_lt_b, eq
  );
endinterface

// File: rtl/subtrator_completo.sv
// Combinational 1-bit full subtractor: D = A - B - Bin, Bout = borrow out.
module subtrator_completo (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  always_comb begin
    d    = 1'b0;
    bout = 1'b0;
    case ({a, b, bin})
      3'b000: begin d = 1'b0; bout = 1'b0; end
      3'b001: begin d = 1'b1; bout = 1'b1; end
      3'b010: begin d = 1'b1; bout = 1'b1; end
      3'b011: begin d = 1'b0; bout = 1'b1; end
      3'b100: begin d = 1'b1; bout = 1'b0; end
      3'b101: begin d = 1'b0; bout = 1'b0; end
      3'b110: begin d = 1'b0; bout = 1'b0; end
      3'b111: begin d = 1'b1; bout = 1'b1; end
      default: begin d = 1'b0; bout = 1'b0; end
    endcase
  end
endmodule

// File: rtl/subtrator_serial.sv
// Bit-serial subtractor/comparator: one full-subtractor cell, LSB first,
// WIDTH cycles per operation, results latched on the final CALC edge.
module subtrator_serial
  import subtrator_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  subtrator_serial_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] d_sh_q, d_sh_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bo_q, bo_d;
  logic             eq_q, eq_d;

  logic cell_d, cell_bo;

  subtrator_completo u_cell (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .bin  (br_q),
    .d    (cell_d),
    .bout (cell_bo)
  );

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    d_sh_d  = d_sh_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bo_d    = bo_q;
    eq_d    = eq_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          br_d    = bus.borrow_in;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        // Difference bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
        d_sh_d = {cell_d, d_sh_q[WIDTH-1:1]};
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        br_d   = cell_bo;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          diff_d  = d_sh_d;
          bo_d    = cell_bo;
          eq_d    = (d_sh_d == '0) & ~cell_bo;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      d_sh_q  <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bo_q    <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      d_sh_q  <= d_sh_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bo_q    <= bo_d;
      eq_q    <= eq_d;
    end
  end

  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = (state_q == DONE);
  assign bus.diff       = diff_q;
  assign bus.borrow_out = bo_q;
  assign bus.a_lt_b     = bo_q;
  assign bus.eq         = eq_q;
endmodule

// File: tb/tb_subtrator_serial.sv
// Directed bench for subtrator_serial: hand-computed vectors, latency,
// ignored start, async reset mid-operation and back-to-back starts.
module tb_subtrator_serial;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  subtrator_serial_if #(.WIDTH(8)) bus ();

  subtrator_serial #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until done is seen, bounded at 20.
  task automatic wait_done(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.done && n < 20);
  endtask

  task automatic chk_res(input string tag, input logic [7:0] ed, input logic ebo, input logic eeq);
    chk({tag, " diff"}, 32'(bus.diff), 32'(ed));
    chk({tag, " borrow_out"}, 32'(bus.borrow_out), 32'(ebo));
    chk({tag, " a_lt_b"}, 32'(bus.a_lt_b), 32'(ebo));
    chk({tag, " eq"}, 32'(bus.eq), 32'(eeq));
  endtask

  task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                        input logic tbi, input logic [7:0] ed, input logic ebo, input logic eeq);
    int n;
    bus.a = ta; bus.b = tb_v; bus.borrow_in = tbi; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk({tag, " busy"}, 32'(bus.busy), 32'd1);
    chk({tag, " no early done"}, 32'(bus.done), 32'd0);
    wait_done(n);
    chk({tag, " latency"}, 32'(n), 32'd8);
    chk_res(tag, ed, ebo, eeq);
    step();
    chk({tag, " done one cycle"}, 32'(bus.done), 32'd0);
    chk({tag, " idle"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int n, dcnt, last_done, prev_done, prev2_done;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.borrow_in = 1'b0;

    #12;
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset done", 32'(bus.done), 32'd0);
    chk_res("reset", 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();

    run_op("5A-3C", 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0);
    run_op("3C-5A", 8'h3C, 8'h5A, 1'b0, 8'hE2, 1'b1, 1'b0);
    run_op("77-77", 8'h77, 8'h77, 1'b0, 8'h00, 1'b0, 1'b1);
    run_op("10-0F-1", 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b1);

    // Wrap-around with a second start pulsed mid-calculation.
    bus.a = 8'h00; bus.b = 8'h01; bus.borrow_in = 1'b0; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    bus.a = 8'hFF; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    wait_done(n);
    chk("wrap latency", 32'(n), 32'd6);
    chk_res("wrap", 8'hFF, 1'b1, 1'b0);
    dcnt = 0;
    repeat (12) begin
      step();
      if (bus.done) dcnt++;
    end
    chk("wrap single done", 32'(dcnt), 32'd0);
    chk_res("wrap hold", 8'hFF, 1'b1, 1'b0);

    // Async reset with cnt==4.
    bus.a = 8'hA5; bus.b = 8'h5A; bus.borrow_in = 1'b0; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (4) step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst busy", 32'(bus.busy), 32'd0);
    chk("arst done", 32'(bus.done), 32'd0);
    chk_res("arst", 8'h00, 1'b0, 1'b0);
    dcnt = 0;
    repeat (3) begin
      step();
      if (bus.done || bus.busy) dcnt++;
    end
    #3 rst_n = 1'b1;
    repeat (10) begin
      step();
      if (bus.done) dcnt++;
    end
    chk("arst no done", 32'(dcnt), 32'd0);
    run_op("A5-5A", 8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0, 1'b0);

    // start held high: accepted every 10 cycles.
    bus.a = 8'h81; bus.b = 8'h02; bus.borrow_in = 1'b0; bus.start = 1'b1;
    dcnt = 0; last_done = -1; prev_done = 0; prev2_done = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (prev_done) chk("held gap busy", 32'(bus.busy), 32'd0);
      if (prev2_done) chk("held restart busy", 32'(bus.busy), 32'd1);
      prev2_done = prev_done;
      prev_done = 0;
      if (bus.done) begin
        dcnt++;
        chk_res("held", 8'h7F, 1'b0, 1'b0);
        if (last_done >= 0) chk("held period", 32'(i - last_done), 32'd10);
        last_done = i;
        prev_done = 1;
      end
    end
    bus.start = 1'b0;
    chk("held done count", 32'(dcnt), 32'd3);
    repeat (12) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
